// File: rtl/md_pad_pkg.sv
// Shared definitions for the MD-family message padder: FSM state encoding,
// block geometry and the fixed 64-bit length field width.
// No ports; imported by md_padder and md_byte_packer.
package md_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD80,
    ST_ZERO,
    ST_LEN,
    ST_FLUSH
  } state_e;

  localparam int          BLOCK_BYTES = 64;
  localparam int          LEN_POS     = 56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  localparam int          LEN_WIDTH   = 64;
  localparam int          POS_W       = $clog2(BLOCK_BYTES);

endpackage

// File: rtl/md_byte_packer.sv
// Packs a byte stream into 32-bit words: 3-byte assembler plus one output register.
// Latency: a word is valid the cycle after its 4th byte is accepted.
// Backpressure: byte_rdy_o drops only when a 4th byte has nowhere to go (output full, not being taken).
// Ports: clk_i/rst_i (sync, active high); byte_vld_i/byte_dat_i/byte_rdy_o byte side with
// last_blk_i/last_msg_i flags for the byte; word_o/word_vld_o/word_rdy_i and
// word_last_blk_o/word_last_msg_o word side.
module md_byte_packer
  import md_pad_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  input  logic        last_blk_i,
  input  logic        last_msg_i,
  output logic        byte_rdy_o,
  output logic [31:0] word_o,
  output logic        word_vld_o,
  input  logic        word_rdy_i,
  output logic        word_last_blk_o,
  output logic        word_last_msg_o
);

  logic [1:0]      cnt_q, cnt_d;
  logic [2:0][7:0] asm_q, asm_d;
  logic [31:0]     word_q, word_d;
  logic            vld_q, vld_d;
  logic            lb_q, lb_d;
  logic            lm_q, lm_d;
  logic            take;

  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    word_d = word_q;
    vld_d  = vld_q;
    lb_d   = lb_q;
    lm_d   = lm_q;
    // Only the word-completing byte can be blocked; bytes 1..3 always fit.
    byte_rdy_o = !((cnt_q == 2'd3) && vld_q && !word_rdy_i);
    take       = byte_vld_i && byte_rdy_o;
    if (vld_q && word_rdy_i) begin
      vld_d = 1'b0;
    end
    if (take) begin
      if (cnt_q == 2'd3) begin
        if (BIG_ENDIAN) begin
          word_d = {asm_q[0], asm_q[1], asm_q[2], byte_dat_i};
        end else begin
          word_d = {byte_dat_i, asm_q[2], asm_q[1], asm_q[0]};
        end
        vld_d = 1'b1;
        lb_d  = last_blk_i;
        lm_d  = last_msg_i;
        cnt_d = 2'd0;
      end else begin
        asm_d[cnt_q] = byte_dat_i;
        cnt_d        = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      asm_q  <= '0;
      word_q <= 32'd0;
      vld_q  <= 1'b0;
      lb_q   <= 1'b0;
      lm_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      word_q <= word_d;
      vld_q  <= vld_d;
      lb_q   <= lb_d;
      lm_q   <= lm_d;
    end
  end

  assign word_o          = word_q;
  assign word_vld_o      = vld_q;
  assign word_last_blk_o = lb_q;
  assign word_last_msg_o = lm_q;

endmodule

// File: rtl/md_padder.sv
// MD/SHA message padder: FWFT byte stream in, padded 512-bit blocks out as 16 x 32-bit words.
// Latency: 1 byte/cycle; first INPUT_READ the cycle after START; DONE one cycle after last word accepted.
// Backpressure: WORD_READY low stalls byte intake and padding once the packer is full.
// Ports: CLK, RESET (sync, active high); START_IN/INPUT_SIZE_IN/BUSY_OUT/DONE_OUT control;
// INPUT_BYTE/INPUT_EMPTY/INPUT_READ FIFO side; WORD_OUT/WORD_VALID/WORD_READY/
// WORD_LAST_BLOCK/WORD_LAST_MSG word side.
module md_padder
  import md_pad_pkg::*;
#(
  parameter int SIZE_WIDTH = 64,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START_IN,
  output logic                  BUSY_OUT,
  output logic                  DONE_OUT,
  input  logic [SIZE_WIDTH-1:0] INPUT_SIZE_IN,
  input  logic [7:0]            INPUT_BYTE,
  input  logic                  INPUT_EMPTY,
  output logic                  INPUT_READ,
  output logic [31:0]           WORD_OUT,
  output logic                  WORD_VALID,
  input  logic                  WORD_READY,
  output logic                  WORD_LAST_BLOCK,
  output logic                  WORD_LAST_MSG
);

  state_e                  state_q, state_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [SIZE_WIDTH-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [2:0]              idx_q, idx_d;
  logic                    done_q, done_d;

  logic                    byte_vld, pk_rdy, last_msg, last_blk;
  logic [7:0]              byte_dat;

  // Bit length {size, 3'b000}, zero-extended then cut to the 64-bit field.
  logic [SIZE_WIDTH+LEN_WIDTH+2:0] len_ext;
  logic [LEN_WIDTH-1:0]            len_bits;
  logic                            len_unused;
  logic [2:0]                      len_sel;
  logic [7:0]                      len_byte;

  assign len_ext    = {{LEN_WIDTH{1'b0}}, size_q, 3'b000};
  assign len_bits   = len_ext[LEN_WIDTH-1:0];
  assign len_unused = ^len_ext[SIZE_WIDTH+LEN_WIDTH+2:LEN_WIDTH];
  // Big-endian sends byte 7 first: 7-idx is the bitwise inverse for 3 bits.
  assign len_sel    = BIG_ENDIAN ? ~idx_q : idx_q;
  assign len_byte   = len_bits[{len_sel, 3'b000} +: 8];
  assign last_blk   = (pos_q == POS_W'(BLOCK_BYTES - 1));

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    byte_vld   = 1'b0;
    byte_dat   = 8'h00;
    last_msg   = 1'b0;
    INPUT_READ = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done_q blocks the restart in the DONE cycle itself.
        if (START_IN && !done_q) begin
          size_d  = INPUT_SIZE_IN;
          cnt_d   = '0;
          pos_d   = '0;
          idx_d   = 3'd0;
          state_d = (INPUT_SIZE_IN == '0) ? ST_PAD80 : ST_DATA;
        end
      end
      ST_DATA: begin
        byte_vld = !INPUT_EMPTY;
        byte_dat = INPUT_BYTE;
        if (byte_vld && pk_rdy) begin
          INPUT_READ = !RESET;
          cnt_d      = cnt_q + SIZE_WIDTH'(1);
          if (cnt_q == size_q - SIZE_WIDTH'(1)) state_d = ST_PAD80;
        end
      end
      ST_PAD80: begin
        byte_vld = 1'b1;
        byte_dat = PAD_BYTE;
        // Skip ZERO entirely when 0x80 lands just before the length field.
        if (pk_rdy) state_d = (pos_q == POS_W'(LEN_POS - 1)) ? ST_LEN : ST_ZERO;
      end
      ST_ZERO: begin
        byte_vld = 1'b1;
        if (pk_rdy && (pos_q == POS_W'(LEN_POS - 1))) state_d = ST_LEN;
      end
      ST_LEN: begin
        byte_vld = 1'b1;
        byte_dat = len_byte;
        last_msg = (idx_q == 3'd7);
        if (pk_rdy) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (WORD_VALID && WORD_READY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (byte_vld && pk_rdy) pos_d = pos_q + POS_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign BUSY_OUT = (state_q != ST_IDLE);
  assign DONE_OUT = done_q;

  md_byte_packer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_packer (
    .clk_i          (CLK),
    .rst_i          (RESET),
    .byte_vld_i     (byte_vld),
    .byte_dat_i     (byte_dat),
    .last_blk_i     (last_blk),
    .last_msg_i     (last_msg),
    .byte_rdy_o     (pk_rdy),
    .word_o         (WORD_OUT),
    .word_vld_o     (WORD_VALID),
    .word_rdy_i     (WORD_READY),
    .word_last_blk_o(WORD_LAST_BLOCK),
    .word_last_msg_o(WORD_LAST_MSG)
  );

endmodule
